// File: rtl/spi_serv_pkg.sv
// rtl/spi_serv_pkg.sv - frame layout, response layout and FSM encoding for spi_master_serv
package spi_serv_pkg;

  localparam int FRAME_BITS  = 72;
  localparam int RSP_BITS    = 40;
  localparam int ADR_MSB     = 71;
  localparam int DAT_MSB     = 39;
  localparam int WE_BIT      = 3;
  localparam int START_BIT   = 2;
  localparam int SYS_RST_BIT = 1;
  localparam int CPU_RST_BIT = 0;
  localparam int CNT_W       = 7;
  localparam int RSP_DAT_W   = 32;
  localparam int STATUS_W    = 3;
  // Only read data and status survive; response bits [7:3] are never stored.
  localparam int RSP_KEEP    = RSP_DAT_W + STATUS_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } state_e;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [31:0] adr,
    input logic [31:0] dat,
    input logic        we,
    input logic        start,
    input logic        sys_reset,
    input logic        cpu_reset
  );
    logic [FRAME_BITS-1:0] f;
    f                = '0;
    f[ADR_MSB -: 32] = adr;
    f[DAT_MSB -: 32] = dat;
    f[WE_BIT]        = we;
    f[START_BIT]     = start;
    f[SYS_RST_BIT]   = sys_reset;
    f[CPU_RST_BIT]   = cpu_reset;
    return f;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK divider with rise/fall strobes; SCLK held low while disabled
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic rise_o,
  output logic fall_o,
  output logic sclk_o
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] div_q;
  logic          sclk_q;
  logic          tick;

  // Strobes fire in the cycle whose closing edge toggles SCLK.
  assign tick   = en_i && (div_q == DW'(CLK_DIV - 1));
  assign rise_o = tick && !sclk_q;
  assign fall_o = tick && sclk_q;
  assign sclk_o = sclk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else if (!en_i) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else if (tick) begin
      div_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      div_q  <= div_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_serv.sv
// rtl/spi_master_serv.sv - SPI mode-0 master for the serv debug/loader bridge
// SPI_START_CLEAR_EN: re-send each start=1 frame with start=0 before reporting the response.
module spi_master_serv
  import spi_serv_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_GUARD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_dat,
  input  logic        i_we,
  input  logic        i_start,
  input  logic        i_sys_reset,
  input  logic        i_cpu_reset,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_dat,
  output logic [2:0]  o_rsp_status,
  output logic        o_busy,
  output logic        o_sclk,
  output logic        o_cs_n,
  output logic        o_mosi,
  input  logic        i_miso
);

  if (CLK_DIV < 2) begin : g_clk_div_check
    $error("spi_master_serv: CLK_DIV must be >= 2");
  end
  if (CS_GUARD < 1) begin : g_cs_guard_check
    $error("spi_master_serv: CS_GUARD must be >= 1");
  end

  localparam int GW = (CS_GUARD > 1) ? $clog2(CS_GUARD) : 1;

  state_e                state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [RSP_KEEP-1:0]   rsp_sh_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [GW-1:0]         guard_q;
  logic                  cs_n_q;
  logic                  rsp_valid_q;
  logic [31:0]           rsp_dat_q;
  logic [2:0]            rsp_status_q;
`ifdef SPI_START_CLEAR_EN
  logic [FRAME_BITS-1:0] cmd_q;
  logic                  gap_q;
`endif

  logic [FRAME_BITS-1:0] frame_d;
  logic                  sclk_rise;
  logic                  sclk_fall;
  logic                  guard_done;
  logic                  rsp_keep;

  assign frame_d    = build_frame(i_adr, i_dat, i_we, i_start, i_sys_reset, i_cpu_reset);
  assign guard_done = (guard_q == GW'(CS_GUARD - 1));
  assign rsp_keep   = (bit_cnt_q < CNT_W'(RSP_DAT_W)) ||
                      ((bit_cnt_q >= CNT_W'(RSP_BITS - STATUS_W)) && (bit_cnt_q < CNT_W'(RSP_BITS)));

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q == ST_SHIFT),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall),
    .sclk_o (o_sclk)
  );

  // MOSI is the MSB of the shifter; 72 shifts leave it zero between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      rsp_sh_q     <= '0;
      bit_cnt_q    <= '0;
      guard_q      <= '0;
      cs_n_q       <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= '0;
`ifdef SPI_START_CLEAR_EN
      cmd_q        <= '0;
      gap_q        <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            shift_q   <= frame_d;
            cs_n_q    <= 1'b0;
            guard_q   <= '0;
            bit_cnt_q <= '0;
`ifdef SPI_START_CLEAR_EN
            cmd_q     <= frame_d;
`endif
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (guard_done) begin
            guard_q <= '0;
            state_q <= ST_SHIFT;
          end else begin
            guard_q <= guard_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (sclk_rise && rsp_keep) begin
            rsp_sh_q <= {rsp_sh_q[RSP_KEEP-2:0], i_miso};
          end
          if (sclk_fall) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
            if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
              state_q <= ST_HOLD;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (guard_done) begin
            guard_q <= '0;
`ifdef SPI_START_CLEAR_EN
            // gap_q marks the CS_n-high interval before the start-clearing resend.
            if (gap_q) begin
              gap_q     <= 1'b0;
              cs_n_q    <= 1'b0;
              shift_q   <= cmd_q;
              bit_cnt_q <= '0;
              state_q   <= ST_SETUP;
            end else if (cmd_q[START_BIT]) begin
              gap_q            <= 1'b1;
              cs_n_q           <= 1'b1;
              cmd_q[START_BIT] <= 1'b0;
            end else
`endif
            begin
              cs_n_q       <= 1'b1;
              rsp_valid_q  <= 1'b1;
              rsp_dat_q    <= rsp_sh_q[RSP_KEEP-1:STATUS_W];
              rsp_status_q <= rsp_sh_q[STATUS_W-1:0];
              state_q      <= ST_DONE;
            end
          end else begin
            guard_q <= guard_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_ready  = (state_q == ST_IDLE);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_cs_n       = cs_n_q;
  assign o_mosi       = shift_q[FRAME_BITS-1];
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_dat    = rsp_dat_q;
  assign o_rsp_status = rsp_status_q;

endmodule

// File: tb/tb_spi_master_serv.sv
// tb/tb_spi_master_serv.sv - scoreboard bench for spi_master_serv with a MISO slave model
module tb_spi_master_serv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        c_valid = 1'b0, c_we = 1'b0, c_start = 1'b0, c_sys = 1'b0, c_cpu = 1'b0, miso = 1'b0;
  logic [31:0] c_adr = '0, c_dat = '0;
  logic        ready, rsp_valid, busy, sclk, cs_n, mosi;
  logic [31:0] rsp_dat;
  logic [2:0]  rsp_status;

  spi_master_serv dut (
    .clk(clk), .rst(rst), .i_cmd_valid(c_valid), .o_cmd_ready(ready),
    .i_adr(c_adr), .i_dat(c_dat), .i_we(c_we), .i_start(c_start),
    .i_sys_reset(c_sys), .i_cpu_reset(c_cpu), .o_rsp_valid(rsp_valid),
    .o_rsp_dat(rsp_dat), .o_rsp_status(rsp_status), .o_busy(busy),
    .o_sclk(sclk), .o_cs_n(cs_n), .o_mosi(mosi), .i_miso(miso)
  );

  logic        d1_valid = 1'b0, d1_miso = 1'b0;
  logic        d1_ready, d1_rsp_valid, d1_busy, d1_sclk, d1_cs_n, d1_mosi;
  logic [31:0] d1_rsp_dat;
  logic [2:0]  d1_rsp_status;

  spi_master_serv #(.CLK_DIV(2), .CS_GUARD(1)) dut1 (
    .clk(clk), .rst(rst), .i_cmd_valid(d1_valid), .o_cmd_ready(d1_ready),
    .i_adr(32'h8000_0001), .i_dat(32'h0F0F_0F0F), .i_we(1'b0), .i_start(1'b0),
    .i_sys_reset(1'b1), .i_cpu_reset(1'b1), .o_rsp_valid(d1_rsp_valid),
    .o_rsp_dat(d1_rsp_dat), .o_rsp_status(d1_rsp_status), .o_busy(d1_busy),
    .o_sclk(d1_sclk), .o_cs_n(d1_cs_n), .o_mosi(d1_mosi), .i_miso(d1_miso)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct packed {
    logic [71:0] first;
    logic [71:0] last;
    logic [31:0] nfr;
    logic [31:0] dat;
    logic [2:0]  st;
    logic [31:0] lat;
    logic [31:0] gaps;
  } exp_t;

  exp_t sb[$];

  // Slave model and response monitor share one block so frame capture precedes the compare.
  logic [39:0] slave_rsp = '0;
  logic [39:0] miso_sh = '0;
  logic [71:0] mosi_cap = '0, first_frame = '0, last_frame = '0;
  int          rise_cnt = 0, last_rises = 0, nfr = 0, busy_cs_hi = 0, acc_cyc = 0;
  logic        p_cs = 1'b1, p_sclk = 1'b0;
  exp_t        e;

  always @(negedge clk) begin
    if (c_valid && ready) begin
      acc_cyc    = cyc;
      nfr        = 0;
      busy_cs_hi = 0;
      rise_cnt   = 0;
    end
    if (p_cs && !cs_n) begin
      rise_cnt = 0;
      mosi_cap = '0;
      miso_sh  = slave_rsp;
      miso     = miso_sh[39];
    end
    if (!cs_n && sclk && !p_sclk) begin
      mosi_cap = {mosi_cap[70:0], mosi};
      rise_cnt++;
    end
    if (!cs_n && !sclk && p_sclk) begin
      miso_sh = {miso_sh[38:0], 1'b0};
      miso    = miso_sh[39];
    end
    if (!p_cs && cs_n) begin
      if (nfr == 0) first_frame = mosi_cap;
      last_frame = mosi_cap;
      last_rises = rise_cnt;
      nfr++;
    end
    if (busy && cs_n) busy_cs_hi++;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=1 required=0");
      end else begin
        e = sb.pop_front();
        chk("rsp_dat", 72'(rsp_dat), 72'(e.dat));
        chk("rsp_status", 72'(rsp_status), 72'(e.st));
        chk("mosi_first_frame", first_frame, e.first);
        chk("mosi_last_frame", last_frame, e.last);
        chk("frame_count", 72'(nfr), 72'(e.nfr));
        chk("sclk_rises", 72'(last_rises), 72'd72);
        chk("latency", 72'(cyc - acc_cyc + 1), 72'(e.lat));
        chk("cs_high_while_busy", 72'(busy_cs_hi), 72'(e.gaps));
      end
    end
    p_cs   = cs_n;
    p_sclk = sclk;
  end

  task automatic send(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                      input logic st, input logic sy, input logic cp, input logic [71:0] xframe,
                      input logic [39:0] pat, input logic [31:0] xdat, input logic [2:0] xst);
    exp_t x;
    int   n;
    x.first = xframe;
    x.last  = xframe;
    x.nfr   = 1;
    x.lat   = 582;
    x.gaps  = 1;
    x.dat   = xdat;
    x.st    = xst;
`ifdef SPI_START_CLEAR_EN
    if (st) begin
      x.last = xframe & ~72'h4;
      x.nfr  = 2;
      x.lat  = 1164;
      x.gaps = 3;
    end
`endif
    n = 0;
    @(posedge clk); #1;
    while (!ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) chk("ready_timeout", 72'd0, 72'd1);
    sb.push_back(x);
    slave_rsp = pat;
    c_adr = adr; c_dat = dat; c_we = we; c_start = st; c_sys = sy; c_cpu = cp;
    c_valid = 1'b1;
    @(posedge clk); #1;
    c_valid = 1'b0;
    c_adr = ~adr; c_dat = ~dat; c_we = ~we; c_start = ~st; c_sys = ~sy; c_cpu = ~cp;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("rsp_timeout", 72'd0, 72'd1);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_rises(input int target);
    int n;
    n = 0;
    while (rise_cnt < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (rise_cnt < target) chk("rise_wait_timeout", 72'(rise_cnt), 72'(target));
  endtask

  initial begin
    int t_acc, t_cs, r1, r2, t_rsp, rises, viol;
    logic [71:0] cap;
    logic p_m, p_s, p_rise;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 72'(cs_n), 72'd1);
    chk("rst_sclk", 72'(sclk), 72'd0);
    chk("rst_mosi", 72'(mosi), 72'd0);
    chk("rst_rsp_valid", 72'(rsp_valid), 72'd0);
    chk("rst_rsp_dat", 72'(rsp_dat), 72'd0);
    chk("rst_rsp_status", 72'(rsp_status), 72'd0);
    chk("rst_busy", 72'(busy), 72'd0);
    chk("rst_cmd_ready", 72'(ready), 72'd1);
    rst = 1'b0;

    send(32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0, 72'h00001000_DEADBEEF_0C,
         40'h12345678_05, 32'h1234_5678, 3'b101);
    wait_done();
    repeat (5) @(posedge clk);
    #1;
    chk("rsp_dat_hold", 72'(rsp_dat), 72'h1234_5678);

    send(32'hA5A5_0004, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 72'hA5A50004_00000000_02,
         40'hCAFEF00D_FF, 32'hCAFE_F00D, 3'b111);
    wait_rises(20);
    @(posedge clk); #1;
    c_adr   = 32'h5555_AAAA;
    c_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_cmd_ready", 72'(ready), 72'd0);
    chk("busy_flag", 72'(busy), 72'd1);
    c_valid = 1'b0;
    wait_done();

    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 72'hFFFFFFFF_00000001_01,
         40'h00000000_00, 32'h0, 3'b000);
    wait_rises(30);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_cs_n", 72'(cs_n), 72'd1);
    chk("midrst_sclk", 72'(sclk), 72'd0);
    chk("midrst_busy", 72'(busy), 72'd0);
    chk("midrst_rsp_dat", 72'(rsp_dat), 72'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);

    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 72'hFFFFFFFF_00000001_01,
         40'h80000001_F8, 32'h8000_0001, 3'b000);
    wait_done();

    t_acc = -1; t_cs = -1; r1 = -1; r2 = -1; t_rsp = -1; rises = 0; viol = 0;
    cap = '0; p_s = 1'b0; p_rise = 1'b0;
    @(posedge clk); #1;
    d1_valid = 1'b1;
    @(negedge clk);
    chk("d1_ready", 72'(d1_ready), 72'd1);
    t_acc = cyc;
    p_m = d1_mosi;
    @(posedge clk); #1;
    d1_valid = 1'b0;
    for (int k = 0; k < 400 && t_rsp < 0; k++) begin
      @(negedge clk);
      if (!d1_cs_n && t_cs < 0) t_cs = cyc;
      if (p_rise && d1_mosi !== p_m) viol++;
      p_rise = 1'b0;
      if (d1_sclk && !p_s) begin
        if (r1 < 0) r1 = cyc;
        else if (r2 < 0) r2 = cyc;
        if (d1_mosi !== p_m) viol++;
        cap = {cap[70:0], d1_mosi};
        rises++;
        p_rise = 1'b1;
      end
      if (d1_rsp_valid) t_rsp = cyc;
      p_s = d1_sclk;
      p_m = d1_mosi;
    end
    chk("d1_cs_fall_delay", 72'(t_cs - t_acc), 72'd1);
    chk("d1_first_rise", 72'(r1 - t_cs), 72'd3);
    chk("d1_sclk_period", 72'(r2 - r1), 72'd4);
    chk("d1_latency", 72'(t_rsp - t_acc + 1), 72'd292);
    chk("d1_rises", 72'(rises), 72'd72);
    chk("d1_frame", cap, 72'h80000001_0F0F0F0F_03);
    chk("d1_mosi_stable", 72'(viol), 72'd0);
    chk("d1_rsp_dat", 72'(d1_rsp_dat), 72'd0);

    repeat (10) @(posedge clk);
    chk("sb_drained", 72'(sb.size()), 72'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
